snoop_responder: RTL and testbench

SNOOP_RESPONDER -- requirements
Module: snoop_responder

---
 rtl/snoop_responder_pkg.sv | 37 +++
 rtl/snoop_responder_if.sv | 44 ++++
 rtl/snoop_line_table.sv | 53 +++++
 rtl/snoop_responder.sv | 161 ++++++++++++++++
 tb/tb_snoop_responder.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snoop_responder_pkg.sv
// Shared encodings for the snoop responder and its local cache:
// MSI line states, bus/local opcodes and responder FSM states.
package snoop_responder_pkg;

    typedef enum logic [1:0] {
        MSI_I = 2'b00,
        MSI_S = 2'b01,
        MSI_M = 2'b10
    } msi_t;

    typedef enum logic [1:0] {
        BUS_RSV = 2'b00,
        BUS_RD  = 2'b01,
        BUS_RDX = 2'b10,
        BUS_INV = 2'b11
    } bus_op_t;

    typedef enum logic [1:0] {
        LOC_NOP   = 2'b00,
        LOC_FILL  = 2'b01,
        LOC_WRM   = 2'b10,
        LOC_EVICT = 2'b11
    } loc_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOOKUP = 2'b01,
        ST_WB     = 2'b10,
        ST_RESP   = 2'b11
    } fsm_t;

    // State a snooped hit leaves behind: only BusRd keeps a shared copy.
    function automatic msi_t snoop_next(bus_op_t op);
        return (op == BUS_RD) ? MSI_S : MSI_I;
    endfunction

endpackage

// File: rtl/snoop_responder_if.sv
// Bus snoop, local update and write-back handshakes of the snoop responder.
// slave is the responder side, master the surrounding system.
interface snoop_responder_if #(
    parameter int TAG_W  = 2,
    parameter int DATA_W = 2
);
    logic              busValid;
    logic [1:0]        busOp;
    logic [TAG_W-1:0]  busTag;
    logic              busReady;
    logic              busDone;
    logic              busHit;
    logic              locValid;
    logic [1:0]        locOp;
    logic [TAG_W-1:0]  locTag;
    logic [DATA_W-1:0] locData;
    logic              locReady;
    logic              wbValid;
    logic [TAG_W-1:0]  wbTag;
    logic [DATA_W-1:0] wbData;
    logic              wbReady;
    logic              invB0;
    logic              invB1;

    modport slave (
        input  busValid, busOp, busTag,
        input  locValid, locOp, locTag, locData,
        input  wbReady,
        output busReady, busDone, busHit,
        output locReady,
        output wbValid, wbTag, wbData,
        output invB0, invB1
    );

    modport master (
        output busValid, busOp, busTag,
        output locValid, locOp, locTag, locData,
        output wbReady,
        input  busReady, busDone, busHit,
        input  locReady,
        input  wbValid, wbTag, wbData,
        input  invB0, invB1
    );
endinterface

// File: rtl/snoop_line_table.sv
// Two-entry tag/state/data store: one write port, two read ports.
// Line 1 resets to a tag with its index bit set so it maps to itself.
module snoop_line_table
    import snoop_responder_pkg::*;
#(
    parameter int TAG_W  = 2,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              widx,
    input  msi_t              wstate,
    input  logic [TAG_W-1:0]  wtag,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ridx0,
    output msi_t              rstate0,
    output logic [TAG_W-1:0]  rtag0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              ridx1,
    output msi_t              rstate1,
    output logic [TAG_W-1:0]  rtag1,
    output logic [DATA_W-1:0] rdata1
);
    localparam logic [TAG_W-1:0] TAG1_RST = TAG_W'(1) << (TAG_W - 1);

    msi_t              st_q   [2];
    logic [TAG_W-1:0]  tag_q  [2];
    logic [DATA_W-1:0] data_q [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q[0]   <= MSI_I;
            st_q[1]   <= MSI_I;
            tag_q[0]  <= '0;
            tag_q[1]  <= TAG1_RST;
            data_q[0] <= '0;
            data_q[1] <= '0;
        end else if (we) begin
            st_q[widx]   <= wstate;
            tag_q[widx]  <= wtag;
            data_q[widx] <= wdata;
        end
    end

    assign rstate0 = st_q[ridx0];
    assign rtag0   = tag_q[ridx0];
    assign rdata0  = data_q[ridx0];
    assign rstate1 = st_q[ridx1];
    assign rtag1   = tag_q[ridx1];
    assign rdata1  = data_q[ridx1];

endmodule

// File: rtl/snoop_responder.sv
// MSI snoop responder for a two-line cache: looks up snooped bus ops,
// writes back modified lines and applies local cache updates when idle.
module snoop_responder
    import snoop_responder_pkg::*;
#(
    parameter int TAG_W  = 2,
    parameter int DATA_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    snoop_responder_if.slave   sif
);
    fsm_t              state_q, state_d;
    bus_op_t           op_q;
    logic [TAG_W-1:0]  tag_q;
    logic              hit_q;
    logic              inv_q;

    logic              bidx;
    logic              lidx;
    msi_t              bst;
    logic [TAG_W-1:0]  btag;
    logic [DATA_W-1:0] bdata;
    msi_t              lst;
    logic [TAG_W-1:0]  ltag;
    logic [DATA_W-1:0] ldata;

    logic              we;
    logic              widx;
    msi_t              wstate;
    logic [TAG_W-1:0]  wtag;
    logic [DATA_W-1:0] wdata;

    logic              idle;
    logic              accept;
    logic              loc_acc;
    logic              lk_hit;
    loc_op_t           loc_op;

    assign bidx    = tag_q[TAG_W-1];
    assign lidx    = sif.locTag[TAG_W-1];
    assign loc_op  = loc_op_t'(sif.locOp);
    assign idle    = (state_q == ST_IDLE) && !rst;
    assign accept  = idle && sif.busValid;
    assign loc_acc = idle && !sif.busValid && sif.locValid;
    assign lk_hit  = (op_q != BUS_RSV) && (bst != MSI_I) && (btag == tag_q);

    snoop_line_table #(
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_tab (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .widx    (widx),
        .wstate  (wstate),
        .wtag    (wtag),
        .wdata   (wdata),
        .ridx0   (bidx),
        .rstate0 (bst),
        .rtag0   (btag),
        .rdata0  (bdata),
        .ridx1   (lidx),
        .rstate1 (lst),
        .rtag1   (ltag),
        .rdata1  (ldata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= BUS_RSV;
            tag_q   <= '0;
            hit_q   <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= bus_op_t'(sif.busOp);
                tag_q <= sif.busTag;
            end
            if (state_q == ST_LOOKUP) begin
                hit_q <= lk_hit;
                inv_q <= lk_hit && (op_q != BUS_RD);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        we      = 1'b0;
        widx    = bidx;
        wstate  = bst;
        wtag    = btag;
        wdata   = bdata;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_LOOKUP;
                end else if (loc_acc) begin
                    widx  = lidx;
                    wtag  = sif.locTag;
                    wdata = sif.locData;
                    unique case (loc_op)
                        LOC_FILL: begin
                            we     = 1'b1;
                            wstate = MSI_S;
                        end
                        LOC_WRM: begin
                            we     = 1'b1;
                            wstate = MSI_M;
                        end
                        LOC_EVICT: begin
                            // Eviction only drops the state; tag/data stay.
                            we     = 1'b1;
                            wstate = MSI_I;
                            wtag   = ltag;
                            wdata  = ldata;
                        end
                        default: we = 1'b0;
                    endcase
                end
            end
            ST_LOOKUP: begin
                if (lk_hit && bst == MSI_M) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_RESP;
                    if (lk_hit && op_q != BUS_RD) begin
                        we     = 1'b1;
                        wstate = MSI_I;
                    end
                end
            end
            ST_WB: begin
                if (sif.wbReady) begin
                    we      = 1'b1;
                    wstate  = snoop_next(op_q);
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign sif.busReady = idle;
    assign sif.locReady = idle && !sif.busValid;
    assign sif.busDone  = !rst && (state_q == ST_RESP);
    assign sif.busHit   = sif.busDone && hit_q;
    assign sif.invB0    = sif.busDone && inv_q && !bidx;
    assign sif.invB1    = sif.busDone && inv_q && bidx;
    assign sif.wbValid  = !rst && (state_q == ST_WB);
    assign sif.wbTag    = btag;
    assign sif.wbData   = bdata;

    // lst is read only to keep the local-side read port fully described.
    logic unused_lst;
    assign unused_lst = ^lst;

endmodule

// File: tb/tb_snoop_responder.sv
// Self-checking bench for snoop_responder: directed vector table,
// hand-written contention/reset sequences and a randomized model run.
module tb_snoop_responder;
    import snoop_responder_pkg::*;

    localparam int TW = 2;
    localparam int DW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    snoop_responder_if #(.TAG_W(TW), .DATA_W(DW)) sif ();

    snoop_responder #(
        .TAG_W  (TW),
        .DATA_W (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    typedef struct {
        int kind;
        int op;
        int tag;
        int data;
        int dly;
        int hit;
        int wb;
        int wbd;
        int inv;
    } vec_t;

    vec_t tv [14];
    int   n_pass = 0;
    int   n_tot  = 0;
    int   m_st [2];
    int   m_tg [2];
    int   m_dt [2];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_st[0] = 0; m_st[1] = 0;
        m_tg[0] = 0; m_tg[1] = 2;
        m_dt[0] = 0; m_dt[1] = 0;
    endtask

    task automatic model_bus(input int op, input int tag, output int hit,
                             output int wb, output int wbd, output int inv);
        int i;
        i   = (tag >> 1) & 1;
        hit = (op != 0 && m_st[i] != 0 && m_tg[i] == tag) ? 1 : 0;
        wb  = (hit == 1 && m_st[i] == 2) ? 1 : 0;
        wbd = m_dt[i];
        inv = (hit == 1 && op != 1) ? (1 << i) : 0;
        if (hit == 1) m_st[i] = (op == 1) ? 1 : 0;
    endtask

    task automatic model_loc(input int op, input int tag, input int data);
        int i;
        i = (tag >> 1) & 1;
        if (op == 3) begin
            m_st[i] = 0;
        end else if (op != 0) begin
            m_st[i] = op;
            m_tg[i] = tag;
            m_dt[i] = data;
        end
    endtask

    task automatic check_lines(input string nm);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_st%0d", nm, i), dut.u_tab.st_q[i], m_st[i]);
            if (m_st[i] != 0) begin
                chk($sformatf("%s_tg%0d", nm, i), dut.u_tab.tag_q[i], m_tg[i]);
                chk($sformatf("%s_dt%0d", nm, i), dut.u_tab.data_q[i], m_dt[i]);
            end
        end
    endtask

    task automatic loc_op(input string nm, input int op, input int tag,
                          input int data);
        int ok;
        ok = 0;
        sif.locValid = 1'b1;
        sif.locOp    = op[1:0];
        sif.locTag   = tag[TW-1:0];
        sif.locData  = data[DW-1:0];
        #1;
        for (int k = 0; k < 8; k++) begin
            if (sif.locReady) begin
                ok = 1;
                break;
            end
            step();
        end
        chk({nm, "_locacc"}, ok, 1);
        @(posedge clk);
        #1;
        sif.locValid = 1'b0;
        if (ok == 1) model_loc(op, tag, data);
    endtask

    task automatic bus_txn(input string nm, input int op, input int tag,
                           input int dly, input int e_hit, input int e_wb,
                           input int e_wbd, input int e_inv);
        chk({nm, "_rdy"}, sif.busReady, 1);
        sif.busValid = 1'b1;
        sif.busOp    = op[1:0];
        sif.busTag   = tag[TW-1:0];
        @(posedge clk);
        #1;
        sif.busValid = 1'b0;
        chk({nm, "_lkdone"}, sif.busDone, 0);
        if (e_wb == 1) begin
            step();
            chk({nm, "_wbv"}, sif.wbValid, 1);
            chk({nm, "_wbtag"}, sif.wbTag, tag);
            chk({nm, "_wbdat"}, sif.wbData, e_wbd);
            for (int k = 0; k < dly; k++) begin
                step();
                chk({nm, "_wbhold"}, {sif.wbValid, sif.wbTag, sif.wbData},
                    {1'b1, tag[TW-1:0], e_wbd[DW-1:0]});
                chk({nm, "_wbwait"}, sif.busDone, 0);
            end
            sif.wbReady = 1'b1;
            @(posedge clk);
            #1;
            sif.wbReady = 1'b0;
        end else begin
            chk({nm, "_nowb"}, sif.wbValid, 0);
            step();
        end
        chk({nm, "_done"}, sif.busDone, 1);
        chk({nm, "_hit"}, sif.busHit, e_hit);
        chk({nm, "_inv"}, {sif.invB1, sif.invB0}, e_inv);
        chk({nm, "_respwb"}, sif.wbValid, 0);
        step();
        chk({nm, "_pulse"}, {sif.busDone, sif.invB1, sif.invB0}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int hit, wb, wbd, inv, ok, seen;
        int op, tag, data, dly;

        sif.busValid = 1'b0; sif.busOp = '0; sif.busTag = '0;
        sif.locValid = 1'b0; sif.locOp = '0; sif.locTag = '0;
        sif.locData  = '0;   sif.wbReady = 1'b0;
        rst = 1'b1;

        tv[0]  = '{0, 1, 1, 3, 0, 0, 0, 0, 0};
        tv[1]  = '{1, 1, 1, 0, 0, 1, 0, 0, 0};
        tv[2]  = '{0, 2, 2, 1, 0, 0, 0, 0, 0};
        tv[3]  = '{1, 2, 2, 0, 3, 1, 1, 1, 2};
        tv[4]  = '{0, 1, 0, 2, 0, 0, 0, 0, 0};
        tv[5]  = '{1, 3, 1, 0, 0, 0, 0, 0, 0};
        tv[6]  = '{1, 1, 3, 0, 0, 0, 0, 0, 0};
        tv[7]  = '{0, 2, 3, 2, 0, 0, 0, 0, 0};
        tv[8]  = '{1, 1, 3, 0, 0, 1, 1, 2, 0};
        tv[9]  = '{1, 1, 3, 0, 0, 1, 0, 0, 0};
        tv[10] = '{1, 0, 3, 0, 0, 0, 0, 0, 0};
        tv[11] = '{1, 3, 0, 0, 1, 1, 0, 0, 1};
        tv[12] = '{1, 2, 3, 0, 0, 1, 0, 0, 2};
        tv[13] = '{0, 3, 0, 0, 0, 0, 0, 0, 0};

        step();
        chk("rst_busReady", sif.busReady, 0);
        chk("rst_outs", {sif.busDone, sif.busHit, sif.wbValid,
                         sif.invB0, sif.invB1, sif.locReady}, 0);
        rst = 1'b0;
        model_reset();
        step();
        chk("post_rst_ready", sif.busReady, 1);
        chk("rst_tag1", dut.u_tab.tag_q[1], 2);
        chk("rst_tag0", dut.u_tab.tag_q[0], 0);
        check_lines("rst");

        for (int v = 0; v < 14; v++) begin
            if (tv[v].kind == 0) begin
                loc_op($sformatf("tv%0d", v), tv[v].op, tv[v].tag, tv[v].data);
            end else begin
                model_bus(tv[v].op, tv[v].tag, hit, wb, wbd, inv);
                bus_txn($sformatf("tv%0d", v), tv[v].op, tv[v].tag, tv[v].dly,
                        tv[v].hit, tv[v].wb, tv[v].wbd, tv[v].inv);
            end
            check_lines($sformatf("tv%0d", v));
        end

        // Bus and local request in the same idle cycle: bus wins.
        sif.busValid = 1'b1; sif.busOp = 2'b01; sif.busTag = 2'b01;
        sif.locValid = 1'b1; sif.locOp = 2'b01; sif.locTag = 2'b10;
        sif.locData  = 2'b11;
        #1;
        chk("race_locReady", sif.locReady, 0);
        chk("race_busReady", sif.busReady, 1);
        @(posedge clk);
        #1;
        sif.busValid = 1'b0;
        model_bus(1, 1, hit, wb, wbd, inv);
        chk("race_lk_locReady", sif.locReady, 0);
        chk("race_lk_line1", dut.u_tab.st_q[1], 0);
        ok = 0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (sif.busDone) seen = 1;
            if (sif.locReady) begin
                ok = 1;
                break;
            end
        end
        chk("race_loc_later", ok, 1);
        chk("race_done_first", seen, 1);
        @(posedge clk);
        #1;
        sif.locValid = 1'b0;
        model_loc(1, 2, 3);
        check_lines("race");

        // Randomized traffic against the reference model.
        for (int r = 0; r < 80; r++) begin
            tag = $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0) begin
                op   = $urandom_range(1, 3);
                data = $urandom_range(0, 3);
                loc_op($sformatf("rnd%0d", r), op, tag, data);
            end else begin
                op  = $urandom_range(0, 3);
                dly = $urandom_range(0, 3);
                model_bus(op, tag, hit, wb, wbd, inv);
                bus_txn($sformatf("rnd%0d", r), op, tag, dly, hit, wb, wbd, inv);
            end
            check_lines($sformatf("rnd%0d", r));
        end

        // Reset while a write-back is pending.
        loc_op("wbrst", 2, 3, 2);
        sif.busValid = 1'b1; sif.busOp = 2'b10; sif.busTag = 2'b11;
        @(posedge clk);
        #1;
        sif.busValid = 1'b0;
        step();
        chk("wbrst_wbv", sif.wbValid, 1);
        rst = 1'b1;
        step();
        chk("wbrst_in_rst", {sif.wbValid, sif.busDone, sif.busReady,
                             sif.locReady}, 0);
        rst = 1'b0;
        model_reset();
        step();
        chk("wbrst_ready", sif.busReady, 1);
        chk("wbrst_quiet", {sif.wbValid, sif.busDone}, 0);
        step();
        chk("wbrst_nodone", sif.busDone, 0);
        check_lines("wbrst");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
